mux_pipe: RTL and testbench

- Parametrised, registered N:1 datapath select stage for inter-stage operand and result selection in the MIPS32 pipeline.
- Generalises the fixed 2/3/5-input combinational selectors to any WIDTH and NSRC.
- Adds a valid/ready handshake with a one-entry skid buffer, so the stage sustains full throughput under backpressure and supports pipeline flush.

---
 rtl/mux_pipe.sv | 130 +++++++++++++
 tb/tb_mux_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_pipe.sv
// mux_pipe: registered N:1 select stage with valid/ready handshake and a
// one-entry skid buffer, so the stage keeps full throughput under backpressure.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   flush_i      drop all held entries at the next edge
//   src_i        flattened sources, source k at [k*WIDTH +: WIDTH]
//   sel_i        source index, sampled with in_valid_i
//   in_valid_i   upstream offers sel_i/src_i this cycle
//   in_ready_o   stage can accept this cycle (registered, = !skid valid)
//   rlt_o        selected, registered result
//   out_valid_o  rlt_o holds a valid entry
//   out_ready_i  downstream takes rlt_o this cycle
//   sel_err_o    sticky out-of-range select flag
//
// Configuration macro: MUX_PIPE_SELERR_EN enables sel_err_o detection; when it
// is undefined sel_err_o is tied to 0.
module mux_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NSRC  = 5,
    parameter int unsigned SELW  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic [NSRC*WIDTH-1:0] src_i,
    input  logic [SELW-1:0]       sel_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [WIDTH-1:0]      rlt_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  sel_err_o
);

    logic [WIDTH-1:0] main_q, main_d;
    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] sel_val;
    logic             accept;
    logic             drain;

    // Out-of-range selects fall through to the last source.
    always_comb begin
        sel_val = src_i[(NSRC-1)*WIDTH +: WIDTH];
        for (int k = 0; k < NSRC; k++) begin
            if (32'(sel_i) == k) begin
                sel_val = src_i[k*WIDTH +: WIDTH];
            end
        end
    end

    assign accept = in_valid_i && !skid_valid_q;
    assign drain  = main_valid_q && out_ready_i;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush_i) begin
            // Data registers keep their contents; only occupancy is cleared.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            if (accept) begin
                main_d       = sel_val;
                main_valid_d = 1'b1;
            end
        end else if (drain) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d = sel_val;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            // Main is stalled: park the new entry in the skid register.
            skid_d       = sel_val;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign rlt_o       = main_q;
    assign out_valid_o = main_valid_q;
    assign in_ready_o  = !skid_valid_q;

`ifdef MUX_PIPE_SELERR_EN
    logic sel_err_q, sel_err_d;

    // Sticky until reset; a dropped flush-cycle input does not count as an accept.
    always_comb begin
        sel_err_d = sel_err_q;
        if (accept && !flush_i && (32'(sel_i) >= NSRC)) begin
            sel_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err_o = sel_err_q;
`else
    assign sel_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mux_pipe.sv
module tb_mux_pipe;

`ifdef MUX_PIPE_SELERR_EN
    localparam bit SelErrEn = 1'b1;
`else
    localparam bit SelErrEn = 1'b0;
`endif

    logic clk;
    logic rst;

    // 32-bit, 5-source instance
    logic          flush32;
    logic [159:0]  src32;
    logic [2:0]    sel32;
    logic          in_valid32;
    logic          in_ready32;
    logic [31:0]   rlt32;
    logic          out_valid32;
    logic          out_ready32;
    logic          sel_err32;

    // 8-bit, 2-source instance
    logic          flush8;
    logic [15:0]   src8;
    logic [0:0]    sel8;
    logic          in_valid8;
    logic          in_ready8;
    logic [7:0]    rlt8;
    logic          out_valid8;
    logic          out_ready8;
    logic          sel_err8;

    int checks   = 0;
    int failures = 0;

    mux_pipe #(.WIDTH(32), .NSRC(5), .SELW(3)) u_dut32 (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush32),
        .src_i       (src32),
        .sel_i       (sel32),
        .in_valid_i  (in_valid32),
        .in_ready_o  (in_ready32),
        .rlt_o       (rlt32),
        .out_valid_o (out_valid32),
        .out_ready_i (out_ready32),
        .sel_err_o   (sel_err32)
    );

    mux_pipe #(.WIDTH(8), .NSRC(2), .SELW(1)) u_dut8 (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush8),
        .src_i       (src8),
        .sel_i       (sel8),
        .in_valid_i  (in_valid8),
        .in_ready_o  (in_ready8),
        .rlt_o       (rlt8),
        .out_valid_o (out_valid8),
        .out_ready_i (out_ready8),
        .sel_err_o   (sel_err8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the stage is a FIFO of at most two entries; the head is
    // what rlt shows, and it can take a new entry whenever it holds fewer than two.
    logic [31:0] q32[$];
    logic [7:0]  q8[$];
    bit          m_init   = 1'b0;
    bit          m_err32  = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (m_init) begin
                chk("ov32", 32'(out_valid32), 32'(q32.size() != 0));
                chk("ir32", 32'(in_ready32), 32'(q32.size() < 2));
                if (q32.size() != 0) chk("rlt32", rlt32, q32[0]);
                chk("err32", 32'(sel_err32), 32'(m_err32));
                chk("ov8", 32'(out_valid8), 32'(q8.size() != 0));
                chk("ir8", 32'(in_ready8), 32'(q8.size() < 2));
                if (q8.size() != 0) chk("rlt8", 32'(rlt8), 32'(q8[0]));
                chk("err8", 32'(sel_err8), 32'd0);
            end
            // Advance the model with the inputs the next rising edge will sample.
            if (rst) begin
                q32.delete();
                q8.delete();
                m_err32 = 1'b0;
                m_init  = 1'b1;
            end else if (m_init) begin
                if (flush32) begin
                    q32.delete();
                end else begin
                    bit acc, drn;
                    int idx;
                    acc = in_valid32 && (q32.size() < 2);
                    drn = (q32.size() != 0) && out_ready32;
                    idx = (int'(sel32) < 5) ? int'(sel32) : 4;
                    if (drn) void'(q32.pop_front());
                    if (acc) q32.push_back(src32[idx*32 +: 32]);
                    if (acc && int'(sel32) >= 5 && SelErrEn) m_err32 = 1'b1;
                end
                if (flush8) begin
                    q8.delete();
                end else begin
                    bit acc, drn;
                    acc = in_valid8 && (q8.size() < 2);
                    drn = (q8.size() != 0) && out_ready8;
                    if (drn) void'(q8.pop_front());
                    if (acc) q8.push_back(src8[int'(sel8)*8 +: 8]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        flush32 = 1'b0; in_valid32 = 1'b0; out_ready32 = 1'b0; sel32 = '0;
        flush8 = 1'b0;  in_valid8 = 1'b0;  out_ready8 = 1'b0;  sel8 = '0; src8 = '0;
        for (int k = 0; k < 5; k++) src32[k*32 +: 32] = 32'h1000_0000 + 32'(k);
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_ov", 32'(out_valid32), 32'd0);
        chk("rst_ir", 32'(in_ready32), 32'd1);
        chk("rst_rlt", rlt32, 32'd0);
        chk("rst_err", 32'(sel_err32), 32'd0);

        // Full throughput, one result per cycle
        in_valid32 = 1'b1; out_ready32 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sel32 = 3'(i);
            step();
            chk("tput_rlt", rlt32, 32'h1000_0000 + 32'(i));
            chk("tput_ov", 32'(out_valid32), 32'd1);
        end
        in_valid32 = 1'b0;
        step();
        chk("tput_empty", 32'(out_valid32), 32'd0);

        // Backpressure fills main then skid
        out_ready32 = 1'b0; in_valid32 = 1'b1; sel32 = 3'd1;
        step();
        chk("bp_rlt1", rlt32, 32'h1000_0001);
        chk("bp_ir1", 32'(in_ready32), 32'd1);
        sel32 = 3'd2;
        step();
        chk("bp_ir0", 32'(in_ready32), 32'd0);
        chk("bp_hold", rlt32, 32'h1000_0001);
        sel32 = 3'd3;
        step();
        chk("bp_hold2", rlt32, 32'h1000_0001);
        chk("bp_ir0b", 32'(in_ready32), 32'd0);
        in_valid32 = 1'b0; out_ready32 = 1'b1;
        step();
        chk("bp_rlt2", rlt32, 32'h1000_0002);
        chk("bp_ir_back", 32'(in_ready32), 32'd1);
        step();
        chk("bp_drained", 32'(out_valid32), 32'd0);

        // Flush with main and skid both occupied
        out_ready32 = 1'b0; in_valid32 = 1'b1; sel32 = 3'd1;
        step();
        sel32 = 3'd2;
        step();
        sel32 = 3'd3; flush32 = 1'b1;
        step();
        chk("fl_ov", 32'(out_valid32), 32'd0);
        chk("fl_ir", 32'(in_ready32), 32'd1);
        flush32 = 1'b0; in_valid32 = 1'b0; out_ready32 = 1'b1;
        step();
        chk("fl_dropped", 32'(out_valid32), 32'd0);

        // Out-of-range select falls through to the last source
        in_valid32 = 1'b1; sel32 = 3'd7;
        step();
        chk("oor_rlt", rlt32, 32'h1000_0004);
        chk("oor_err", 32'(sel_err32), 32'(SelErrEn));
        in_valid32 = 1'b0;
        step();
        flush32 = 1'b1;
        step();
        flush32 = 1'b0;
        chk("oor_err_flush", 32'(sel_err32), 32'(SelErrEn));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("oor_err_rst", 32'(sel_err32), 32'd0);

        // Random handshake traffic on the narrow instance
        for (int i = 0; i < 1000; i++) begin
            in_valid8  = 1'($urandom_range(0, 1));
            out_ready8 = 1'($urandom_range(0, 1));
            sel8       = 1'($urandom_range(0, 1));
            src8       = 16'($urandom);
            step();
        end
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        step();
        step();
        step();
        chk("rnd_empty", 32'(out_valid8), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
